// File: rtl/fdiv_iter.sv
// Multi-cycle binary32 divider: restoring division, BITS_PER_CYCLE quotient bits per cycle, exact RNE.
// Define FDIV_IEEE_SPECIAL_EN for NaN/Inf results; otherwise overflow and x/0 saturate to max finite.
module fdiv_iter #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             dz
);
    localparam int N  = (27 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int QW = N * BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

`ifdef FDIV_IEEE_SPECIAL_EN
    localparam logic [30:0] BIG_MAG = 31'h7F800000;
`else
    localparam logic [30:0] BIG_MAG = 31'h7F7FFFFF;
`endif

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_BIG, SP_NAN} spec_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;

    logic                sgn;
    logic [7:0]          e1, e2;
    logic [23:0]         m1, m2;
    logic [TAG_W-1:0]    tag_r;
    spec_t               spec, spec_in;
    logic                spec_dz, dz_in;
    logic [24:0]         rem, rem_nx;
    logic [QW-1:0]       q, q_nx;
    logic signed [9:0]   ediff;

    logic                zero1, zero2;
`ifdef FDIV_IEEE_SPECIAL_EN
    logic                inf1, inf2, nan1, nan2;
`endif

    function automatic logic [24:0] rne(input logic [23:0] sig, input logic guard,
                                        input logic sticky);
        return {1'b0, sig} + 25'(guard & (sticky | sig[0]));
    endfunction

    // ---- FSM ----
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CALC;
            CALC:    if (cnt == CW'(N)) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn)                cnt <= '0;
        else if (state == CALC)   cnt <= cnt + 1'b1;
        else                      cnt <= '0;
    end

    // ---- operand classification and capture ----
    assign zero1 = (x1[30:23] == 8'd0);
    assign zero2 = (x2[30:23] == 8'd0);
`ifdef FDIV_IEEE_SPECIAL_EN
    assign inf1 = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
    assign inf2 = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
    assign nan1 = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    assign nan2 = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
`endif

    always_comb begin
        spec_in = SP_NONE;
        dz_in   = 1'b0;
`ifdef FDIV_IEEE_SPECIAL_EN
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_in = SP_NAN;
        end else if (inf1) begin
            spec_in = SP_BIG;
        end else if (inf2 || zero1) begin
            spec_in = SP_ZERO;
        end else if (zero2) begin
            spec_in = SP_BIG;
            dz_in   = 1'b1;
        end
`else
        if (zero1) begin
            spec_in = SP_ZERO;
        end else if (zero2) begin
            spec_in = SP_BIG;
            dz_in   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            sgn     <= x1[31] ^ x2[31];
            e1      <= x1[30:23];
            e2      <= x2[30:23];
            m1      <= {1'b1, x1[22:0]};
            m2      <= {1'b1, x2[22:0]};
            tag_r   <= in_tag;
            spec    <= spec_in;
            spec_dz <= dz_in;
        end
    end

    // ---- CALC: first cycle seeds remainder and exponent difference, then N retire cycles ----
    always_comb begin
        logic [24:0]               r;
        logic [BITS_PER_CYCLE-1:0] qb;
        r  = rem;
        qb = '0;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            if (r >= {1'b0, m2}) begin
                qb[i] = 1'b1;
                r     = r - {1'b0, m2};
            end
            r = r << 1;
        end
        rem_nx = r;
        q_nx   = {q[QW-BITS_PER_CYCLE-1:0], qb};
    end

    always_ff @(posedge clk) begin
        if (state == CALC) begin
            if (cnt == '0) begin
                rem   <= {1'b0, m1};
                q     <= '0;
                ediff <= $signed({2'b00, e1}) - $signed({2'b00, e2});
            end else begin
                rem <= rem_nx;
                q   <= q_nx;
            end
        end
    end

    // ---- ROUND: normalise, round to nearest even, range-check ----
    logic [QW-1:0]     qn;
    logic              sticky;
    logic signed [9:0] e_pre, e_post;
    logic [24:0]       sig_r;
    logic [22:0]       frac;
    logic [31:0]       y_nx;
    logic              dz_nx;

    always_comb begin
        qn     = q[QW-1] ? q : (q << 1);
        sticky = (|qn[QW-26:0]) | (|rem);
        e_pre  = q[QW-1] ? (ediff + 10'sd127) : (ediff + 10'sd126);
        sig_r  = rne(qn[QW-1:QW-24], qn[QW-25], sticky);
        e_post = sig_r[24] ? (e_pre + 10'sd1) : e_pre;
        frac   = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
        dz_nx  = spec_dz;
        case (spec)
            SP_ZERO: y_nx = {sgn, 31'd0};
            SP_BIG:  y_nx = {sgn, BIG_MAG};
            SP_NAN:  y_nx = 32'h7FC00000;
            default: begin
                if (e_post >= 10'sd255)    y_nx = {sgn, BIG_MAG};
                else if (e_post <= 10'sd0) y_nx = {sgn, 31'd0};
                else                       y_nx = {sgn, e_post[7:0], frac};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            y       <= '0;
            out_tag <= '0;
            dz      <= 1'b0;
        end else if (state == ROUND) begin
            y       <= y_nx;
            out_tag <= tag_r;
            dz      <= dz_nx;
        end
    end
endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: three instances (1, 2 and 3 quotient bits per cycle) driven in lock-step,
// checked against directed vectors and an integer long-division reference model.
module tb_fdiv_iter;
    localparam int TAG_W = 5;

    logic                       clk = 1'b0;
    logic                       rstn, in_valid, out_ready;
    logic [31:0]                x1, x2;
    logic [TAG_W-1:0]           in_tag;
    logic [2:0]                 in_ready, out_valid, dz;
    logic [2:0][31:0]           y;
    logic [2:0][TAG_W-1:0]      out_tag;

    int checks = 0;
    int errors = 0;

    logic [31:0]      res_y   [3];
    logic [TAG_W-1:0] res_tag [3];
    logic             res_dz  [3];
    int               res_lat [3];
    logic             res_bad [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fdiv_iter #(.BITS_PER_CYCLE(g + 1), .TAG_W(TAG_W)) u_dut (
            .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready[g]),
            .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid[g]),
            .out_ready(out_ready), .y(y[g]), .out_tag(out_tag[g]), .dz(dz[g])
        );
    end

    function automatic int exp_lat(input int g);
        int b;
        b = g + 1;
        return (27 + b - 1) / b + 2;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: exact quotient from one wide integer division, rounded from the spec's rules.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s, guard, sticky;
        int          ea, eb, e;
        logic [63:0] num, den, qq, rr;
        logic [24:0] sig;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
`ifdef FDIV_IEEE_SPECIAL_EN
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 0 && eb == 0) || (ea == 255 && eb == 255))
            return {1'b0, 32'h7FC00000};
        if (ea == 255) return {1'b0, s, 31'h7F800000};
        if (eb == 255 || ea == 0) return {1'b0, s, 31'h0};
        if (eb == 0) return {1'b1, s, 31'h7F800000};
`else
        if (ea == 0) return {1'b0, s, 31'h0};
        if (eb == 0) return {1'b1, s, 31'h7F7FFFFF};
`endif
        num = {40'd0, 1'b1, a[22:0]} << 38;
        den = {40'd0, 1'b1, b[22:0]};
        qq  = num / den;
        rr  = num % den;
        if (qq >= (64'd1 << 38)) begin
            sig    = 25'(qq >> 15);
            guard  = qq[14];
            sticky = (qq[13:0] != 0) || (rr != 0);
            e      = ea - eb + 127;
        end else begin
            sig    = 25'(qq >> 14);
            guard  = qq[13];
            sticky = (qq[12:0] != 0) || (rr != 0);
            e      = ea - eb + 126;
        end
        if (guard && (sticky || sig[0])) sig = sig + 25'd1;
        if (sig == 25'h1000000) begin
            sig = sig >> 1;
            e   = e + 1;
        end
`ifdef FDIV_IEEE_SPECIAL_EN
        if (e >= 255) return {1'b0, s, 31'h7F800000};
`else
        if (e >= 255) return {1'b0, s, 31'h7F7FFFFF};
`endif
        if (e <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], sig[22:0]};
    endfunction

    // One transaction on all three instances with out_ready held high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        logic [2:0] done;
        @(negedge clk);
        x1 = a; x2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        done = '0;
        for (int g = 0; g < 3; g++) begin
            res_lat[g] = 0; res_bad[g] = 1'b0;
        end
        for (int c = 1; c <= 40 && done != 3'b111; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (!done[g]) begin
                    if (out_valid[g]) begin
                        done[g]    = 1'b1;
                        res_lat[g] = c;
                        res_y[g]   = y[g];
                        res_tag[g] = out_tag[g];
                        res_dz[g]  = dz[g];
                    end else if (in_ready[g]) begin
                        res_bad[g] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_op(input string nm, input logic [31:0] ey, input logic [TAG_W-1:0] et,
                            input logic edz);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_y_b%0d", nm, g + 1), 96'(res_y[g]), 96'(ey));
            check($sformatf("%s_tag_b%0d", nm, g + 1), 96'(res_tag[g]), 96'(et));
            check($sformatf("%s_dz_b%0d", nm, g + 1), 96'(res_dz[g]), 96'(edz));
            check($sformatf("%s_lat_b%0d", nm, g + 1), 96'(res_lat[g]), 96'(exp_lat(g)));
            check($sformatf("%s_busy_ready_b%0d", nm, g + 1), 96'(res_bad[g]), 96'd0);
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0:       v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
            2, 3:    v[30:23] = 8'($urandom_range(100, 154));
            4:       v[22:0] = ($urandom_range(0, 1) == 0) ? 23'h7FFFFF : 23'h0;
            default: ;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      y;
        logic             dz;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0]      m;
        logic [31:0]      a, b, hold_y_all;
        logic [95:0]      hold_y;
        logic [14:0]      hold_tag;
        logic [2:0]       hold_dz;
        logic [TAG_W-1:0] t;
        int               cyc;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 5'h01, 32'h40400000, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 5'h13, 32'h3EAAAAAB, 1'b0};
        vecs[2]  = '{32'h00800000, 32'h40000000, 5'h02, 32'h00000000, 1'b0};
        vecs[3]  = '{32'h41200000, 32'h40A00000, 5'h03, 32'h40000000, 1'b0};
        vecs[4]  = '{32'hC0000000, 32'h3F800000, 5'h04, 32'hC0000000, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h3F800000, 5'h05, 32'h80000000, 1'b0};
        vecs[6]  = '{32'h3F800000, 32'h3F800000, 5'h1F, 32'h3F800000, 1'b0};
`ifdef FDIV_IEEE_SPECIAL_EN
        vecs[7]  = '{32'h7F000000, 32'h3E800000, 5'h06, 32'h7F800000, 1'b0};
        vecs[8]  = '{32'hBF800000, 32'h00000000, 5'h07, 32'hFF800000, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 5'h08, 32'h7FC00000, 1'b0};
        vecs[10] = '{32'h3F800000, 32'h80000000, 5'h09, 32'hFF800000, 1'b1};
`else
        vecs[7]  = '{32'h7F000000, 32'h3E800000, 5'h06, 32'h7F7FFFFF, 1'b0};
        vecs[8]  = '{32'hBF800000, 32'h00000000, 5'h07, 32'hFF7FFFFF, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 5'h08, 32'h00000000, 1'b0};
        vecs[10] = '{32'h3F800000, 32'h80000000, 5'h09, 32'hFF7FFFFF, 1'b1};
`endif

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x1 = '0; x2 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 96'(in_ready), 96'(3'b111));
        check("rst_out_valid", 96'(out_valid), 96'd0);
        check("rst_y", 96'(y), 96'd0);
        check("rst_tag", 96'(out_tag), 96'd0);
        check("rst_dz", 96'(dz), 96'd0);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].tag);
            check_op($sformatf("vec%0d", i), vecs[i].y, vecs[i].tag, vecs[i].dz);
        end

        // Back-pressure: results held, new operands ignored, no re-accept on the release edge.
        @(negedge clk);
        out_ready = 1'b0; x1 = 32'h40C00000; x2 = 32'h40000000; in_tag = 5'h0A; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (out_valid != 3'b111 && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("bp_all_valid", 96'(out_valid), 96'(3'b111));
        hold_y = 96'(y); hold_tag = 15'(out_tag); hold_dz = dz;
        hold_y_all = y[0];
        check("bp_y_value", 96'(hold_y_all), 96'h40400000);
        check("bp_tag_value", 96'(out_tag[0]), 96'h0A);
        x1 = 32'h3F800000; x2 = 32'h40400000; in_tag = 5'h11; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", k), 96'(out_valid), 96'(3'b111));
            check($sformatf("bp_hold_y%0d", k), 96'(y), hold_y);
            check($sformatf("bp_hold_tag%0d", k), 96'(out_tag), 96'(hold_tag));
            check($sformatf("bp_hold_dz%0d", k), 96'(dz), 96'(hold_dz));
            check($sformatf("bp_hold_ready%0d", k), 96'(in_ready), 96'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 96'(in_ready), 96'(3'b111));
        check("bp_release_valid", 96'(out_valid), 96'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_stays_idle", 96'(in_ready), 96'(3'b111));

        // Reset mid-CALC aborts the operation.
        @(negedge clk);
        x1 = 32'h3F800000; x2 = 32'h40400000; in_tag = 5'h15; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 96'(in_ready), 96'd0);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        check("abort_in_ready", 96'(in_ready), 96'(3'b111));
        check("abort_out_valid", 96'(out_valid), 96'd0);
        check("abort_y", 96'(y), 96'd0);
        run_op(32'h41200000, 32'h40A00000, 5'h0C);
        check_op("after_abort", 32'h40000000, 5'h0C, 1'b0);

        // Randomised operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            a = rand_fp();
            b = rand_fp();
            t = TAG_W'($urandom);
            m = model(a, b);
            run_op(a, b, t);
            for (int g = 0; g < 3; g++) begin
                check($sformatf("rnd%0d_y_b%0d a=%h b=%h", n, g + 1, a, b), 96'(res_y[g]), 96'(m[31:0]));
                check($sformatf("rnd%0d_dz_b%0d", n, g + 1), 96'(res_dz[g]), 96'(m[32]));
                check($sformatf("rnd%0d_tag_b%0d", n, g + 1), 96'(res_tag[g]), 96'(t));
                check($sformatf("rnd%0d_lat_b%0d", n, g + 1), 96'(res_lat[g]), 96'(exp_lat(g)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
